regfile_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, the successor to the core's 2R/1W regfile. It provides NRD combinational read ports and NWR write ports with same-cycle write-to-read bypass, a hard-wired zero register, and per-register busy tracking. The decode stage uses the busy bits for RAW-hazard interlock; writeback and flush logic release them.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rf_wr_arbiter.sv | 43 ++++
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and write-port priority helper for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned NRD_DEF  = 2;
  localparam int unsigned NWR_DEF  = 2;
  localparam int unsigned ZERO_REG = 0;

  // Upper bound on write ports the priority helper can resolve.
  localparam int unsigned MAX_WR   = 32;

  // Index of the highest-numbered set bit; 0 when no bit is set.
  function automatic int unsigned hi_idx(input logic [MAX_WR-1:0] match);
    int unsigned idx;
    idx = 0;
    for (int unsigned k = 0; k < MAX_WR; k++) begin
      if (match[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_wr_arbiter.sv
// Resolves the write ports against one address: any hit, winning data, any clearing hit.
module rf_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = 5,
  parameter int unsigned NWR  = NWR_DEF
) (
  input  logic [AW-1:0]       addr_i,
  input  logic [NWR-1:0]      wen_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic [NWR-1:0]      wclr_i,
  output logic                hit_c,
  output logic [XLEN-1:0]     data_c,
  output logic                clr_hit_c
);

  logic [NWR-1:0] match;
  logic [NWR-1:0] clr_match;
  int unsigned    sel;

  // Per-port address match, and the subset that also releases the busy bit.
  always_comb begin
    match     = '0;
    clr_match = '0;
    for (int unsigned k = 0; k < NWR; k++) begin
      match[k]     = wen_i[k] && (waddr_i[k*AW +: AW] == addr_i);
      clr_match[k] = match[k] && wclr_i[k];
    end
  end

  assign hit_c     = |match;
  assign clr_hit_c = |clr_match;

  // Highest matching port supplies the data.
  always_comb begin
    sel    = hi_idx(MAX_WR'(match));
    data_c = '0;
    if (hit_c) data_c = wdata_i[sel*XLEN +: XLEN];
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, hard-wired x0 and busy-bit scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEF,
  parameter  int unsigned NREG = NREG_DEF,
  parameter  int unsigned NRD  = NRD_DEF,
  parameter  int unsigned NWR  = NWR_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NWR-1:0]      wclr,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] wr_clr;
  logic [XLEN-1:0] wr_data [NREG];

  // One arbiter per register resolves its write data and busy release; x0 never written.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign wr_hit[r]  = 1'b0;
      assign wr_clr[r]  = 1'b0;
      assign wr_data[r] = '0;
    end else begin : g_arb
      rf_wr_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
        .addr_i    (AW'(r)),
        .wen_i     (wen),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .wclr_i    (wclr),
        .hit_c     (wr_hit[r]),
        .data_c    (wr_data[r]),
        .clr_hit_c (wr_clr[r])
      );
    end
  end

  // Register storage: flop array so that reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_data[r];
      end
    end
  end

  // Busy next-state: clear by writeback, issue overrides clear, flush overrides all.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      if (wr_clr[r]) busy_d[r] = 1'b0;
    end
    if (iss_valid && (iss_rd != AW'(ZERO_REG))) busy_d[iss_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  // Read ports: x0 reads zero, else bypass from a same-cycle write, else storage.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            byp_hit;
    logic            byp_clr;
    logic [XLEN-1:0] byp_data;

    assign ra = raddr[i*AW +: AW];

    rf_wr_arbiter #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_arb (
      .addr_i    (ra),
      .wen_i     (wen),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .wclr_i    (wclr),
      .hit_c     (byp_hit),
      .data_c    (byp_data),
      .clr_hit_c (byp_clr)
    );

    assign rdata[i*XLEN +: XLEN] = (ra == AW'(ZERO_REG)) ? '0 :
                                   byp_hit               ? byp_data : regs_q[ra];
    assign rbusy[i] = (ra != AW'(ZERO_REG)) && busy_q[ra] && !byp_clr;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;
  localparam int unsigned AW   = 5;

  logic                clk;
  logic                rst_n;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NWR-1:0]      wclr;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  int errors = 0;
  int checks = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .wclr      (wclr),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wen       = '0;
    wclr      = '0;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    flush     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    idle();
    #2;

    // Reset state: every address on both ports reads zero and not busy.
    for (int a = 0; a < 32; a++) begin
      raddr[0 +: AW]  = 5'(a);
      raddr[AW +: AW] = 5'(31 - a);
      #1;
      chk($sformatf("rst_rdata0_x%0d", a), rdata[0 +: 64], 64'h0);
      chk($sformatf("rst_rdata1_x%0d", 31 - a), rdata[64 +: 64], 64'h0);
      chk($sformatf("rst_rbusy_%0d", a), 64'(rbusy), 64'h0);
    end
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Write x5 on port 0 and read it in the same cycle.
    @(negedge clk);
    wen = 2'b01; waddr[0 +: AW] = 5'd5; wdata[0 +: 64] = 64'hDEAD_BEEF;
    raddr[0 +: AW] = 5'd5;
    #1;
    chk("x5_bypass", rdata[0 +: 64], 64'hDEAD_BEEF);
    chk("x5_bypass_rbusy", 64'(rbusy[0]), 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("x5_stored", rdata[0 +: 64], 64'hDEAD_BEEF);

    // Both ports write x7; port 1 wins.
    @(negedge clk);
    wen = 2'b11;
    waddr[0 +: AW] = 5'd7;  wdata[0 +: 64]  = 64'h1;
    waddr[AW +: AW] = 5'd7; wdata[64 +: 64] = 64'h2;
    raddr[AW +: AW] = 5'd7;
    #1;
    chk("x7_bypass_prio", rdata[64 +: 64], 64'h2);
    @(negedge clk);
    idle();
    #1;
    chk("x7_stored_prio", rdata[64 +: 64], 64'h2);

    // Writes and issue to x0 are ignored.
    @(negedge clk);
    wen = 2'b01; waddr[0 +: AW] = 5'd0; wdata[0 +: 64] = 64'hFFFF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    raddr[0 +: AW] = 5'd0;
    #1;
    chk("x0_bypass", rdata[0 +: 64], 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("x0_stored", rdata[0 +: 64], 64'h0);
    chk("x0_busy_vec", 64'(busy_vec), 64'h0);

    // Issue x3: old busy visible in the issue cycle, set afterwards.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd3;
    raddr[0 +: AW] = 5'd3;
    #1;
    chk("x3_issue_cycle_rbusy", 64'(rbusy[0]), 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("x3_busy_vec", 64'(busy_vec), 64'h8);
    chk("x3_rbusy_idle1", 64'(rbusy[0]), 64'h1);
    @(negedge clk);
    #1;
    chk("x3_rbusy_idle2", 64'(rbusy[0]), 64'h1);

    // Clearing write to x3: bypassed result does not stall.
    @(negedge clk);
    wen = 2'b01; wclr = 2'b01; waddr[0 +: AW] = 5'd3; wdata[0 +: 64] = 64'h55;
    #1;
    chk("x3_clr_rbusy", 64'(rbusy[0]), 64'h0);
    chk("x3_clr_rdata", rdata[0 +: 64], 64'h55);
    @(negedge clk);
    idle();
    #1;
    chk("x3_clr_busy_vec", 64'(busy_vec), 64'h0);
    chk("x3_clr_stored", rdata[0 +: 64], 64'h55);

    // Non-clearing write keeps x4 busy.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd4;
    @(negedge clk);
    idle();
    wen = 2'b10; wclr = 2'b00; waddr[AW +: AW] = 5'd4; wdata[64 +: 64] = 64'h44;
    raddr[AW +: AW] = 5'd4;
    #1;
    chk("x4_noclr_rbusy", 64'(rbusy[1]), 64'h1);
    chk("x4_noclr_rdata", rdata[64 +: 64], 64'h44);
    @(negedge clk);
    idle();
    #1;
    chk("x4_noclr_busy_vec", 64'(busy_vec), 64'h10);

    // Issue beats a same-cycle clear on x9.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd9;
    wen = 2'b10; wclr = 2'b10; waddr[AW +: AW] = 5'd9; wdata[64 +: 64] = 64'h99;
    @(negedge clk);
    idle();
    #1;
    chk("x9_issue_wins", 64'(busy_vec), 64'h210);

    // Flush beats issue; the write in the flush cycle still lands.
    @(negedge clk);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
    wen = 2'b01; waddr[0 +: AW] = 5'd10; wdata[0 +: 64] = 64'hAB;
    @(negedge clk);
    idle();
    raddr[0 +: AW] = 5'd10;
    #1;
    chk("flush_busy_vec", 64'(busy_vec), 64'h0);
    chk("flush_write_x10", rdata[0 +: 64], 64'hAB);

    // Asynchronous reset mid-stream clears state without a clock edge.
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd12;
    @(negedge clk);
    idle();
    #1;
    chk("x12_busy_before_rst", 64'(busy_vec), 64'h1000);
    raddr[0 +: AW] = 5'd5; raddr[AW +: AW] = 5'd10;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("async_rst_x5", rdata[0 +: 64], 64'h0);
    chk("async_rst_x10", rdata[64 +: 64], 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
